mem_stage_sram_ctrl: RTL and testbench
======================================

// Module: mem_stage_sram_ctrl
// PURPOSE
//   Sequences the MEM stage: takes the EX/MEM-register outputs (MEM_R_EN, MEM_W_EN,
//   ALU_Res as byte address, Val_Rm as store data), runs each 32-bit access as two
//   16-bit accesses on an external SRAM, and drives ready. The hazard unit freezes
//   IF..EX/MEM (freeze = ~ready) while an access is in flight.
//   Sits between the EX/MEM register and the MEM/WB register.
// PARAMETERS
//   DATA_LEN      32    word width; must be 2*SRAM_DATA_LEN
//   SRAM_DATA_LEN 16    SRAM data bus width
//   SRAM_ADDR_LEN 18    SRAM halfword address width
//   BASE_ADDR     1024  byte address that maps to SRAM halfword 0
//   WAIT_CYCLES   2     cycles each halfword access is held on the bus (>=1)
// PORTS
//   clk          in   1              rising-edge clock
//   rst          in   1              async, active-low reset
//   MEM_R_EN     in   1              load request (level, held while ready=0)
//   MEM_W_EN     in   1              store request (level, held while ready=0)
//   ALU_Res      in   DATA_LEN       byte address
//   Val_Rm       in   DATA_LEN       store data
//   ready        out  1              1 = no access pending / access complete
//   rdata        out  DATA_LEN       load result, valid while ready=1 after a load
//   SRAM_ADDR    out  SRAM_ADDR_LEN  halfword address
//   SRAM_DQ_OUT  out  SRAM_DATA_LEN  write data to SRAM
//   SRAM_DQ_IN   in   SRAM_DATA_LEN  read data from SRAM
//   SRAM_DQ_OE   out  1              1 = drive SRAM_DQ_OUT onto the pad
//   SRAM_WE_N    out  1              active-low write strobe
//   addr_err     out  1              only with MEM_RANGE_CHECK_EN; else tied 0
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, ready=1, rdata=0, SRAM_ADDR=0, SRAM_DQ_OUT=0,
//     SRAM_DQ_OE=0, SRAM_WE_N=1, addr_err=0. Reset mid-access aborts it; no strobe
//     remains asserted, no partial rdata update.
//   States: IDLE -> LO -> HI -> DONE -> IDLE.
//   IDLE: no request -> ready=1, stay. Request -> ready=0, latch off=ALU_Res-BASE_ADDR,
//     Val_Rm and op (write wins if R and W both 1, treated as a store), go to LO, cnt=0.
//   LO: SRAM_ADDR={off[SRAM_ADDR_LEN:2],1'b0}; store: DQ_OUT=data[15:0], OE=1, WE_N=0.
//     After WAIT_CYCLES cycles -> HI; load captures SRAM_DQ_IN into rdata[15:0] on last cycle.
//   HI: same with LSB=1, data[31:16] / rdata[31:16]. After WAIT_CYCLES -> DONE.
//   DONE: ready=1 for exactly one cycle, OE=0, WE_N=1; -> IDLE (a new request is seen
//     there next cycle). rdata holds until the next load completes.
//   ready is low for 1+2*WAIT_CYCLES cycles per access (5 at default).
//   WE_N deasserts (1) for at least the cycle between LO and HI: last LO cycle forces WE_N=1.
//   Address bits [1:0] ignored (word aligned); off wraps modulo 2^(SRAM_ADDR_LEN+1).
//   Request inputs are sampled only in IDLE; changes during LO/HI/DONE are ignored.
// CONFIGURATION
//   MEM_RANGE_CHECK_EN defined: in IDLE, if ALU_Res<BASE_ADDR or off >= 2^(SRAM_ADDR_LEN+1)
//     the access is not issued: state -> DONE directly (ready low 1 cycle), addr_err=1
//     during that DONE cycle, rdata unchanged, no SRAM strobe.
//   Undefined: no check, addresses wrap as above, addr_err tied 0.
// STRUCTURE
//   Package mem_ctrl_pkg: state encoding (IDLE/LO/HI/DONE, 2 bits), default widths,
//     BASE_ADDR default constant.
//   Sub-module sram_wait_timer: loadable down-counter, load on state entry,
//     outputs 'expire' on last wait cycle; one instance.
// TESTING
//   Store 0xDEADBEEF @1032 -> SRAM_ADDR 4 gets 0xBEEF (WE_N=0), 5 gets 0xDEAD; ready low 5 cycles.
//   Load @1032 with SRAM model from test 1 -> rdata=0xDEADBEEF on ready=1 cycle.
//   Back-to-back load then store with no gap -> second starts in IDLE the cycle after DONE.
//   MEM_R_EN=MEM_W_EN=1 @1024 data 0x12345678 -> treated as store, halfwords 0x5678/0x1234.
//   rst low during HI of a store -> immediate WE_N=1, OE=0, ready=1, state IDLE.
//   MEM_RANGE_CHECK_EN, load @512 -> addr_err=1 one cycle, no WE_N/addr activity, rdata unchanged.

Source files
------------

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Purpose: shared widths, base address and FSM state encoding for the MEM-stage SRAM controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_ctrl_pkg;

    localparam int DATA_LEN_D      = 32;
    localparam int SRAM_DATA_LEN_D = 16;
    localparam int SRAM_ADDR_LEN_D = 18;
    localparam int BASE_ADDR_D     = 1024;
    localparam int WAIT_CYCLES_D   = 2;

    // IDLE -> LO (low halfword) -> HI (high halfword) -> DONE -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// Purpose: bundles the EX/MEM request side, the load result/ready and the SRAM pins.
// Latency: n/a (wiring only).
// Backpressure: ready from the slave side is the freeze for the master side.
interface mem_stage_sram_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_LEN      = DATA_LEN_D,
    parameter int SRAM_DATA_LEN = SRAM_DATA_LEN_D,
    parameter int SRAM_ADDR_LEN = SRAM_ADDR_LEN_D
);
    logic                     MEM_R_EN;
    logic                     MEM_W_EN;
    logic [DATA_LEN-1:0]      ALU_Res;
    logic [DATA_LEN-1:0]      Val_Rm;
    logic                     ready;
    logic [DATA_LEN-1:0]      rdata;
    logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR;
    logic [SRAM_DATA_LEN-1:0] SRAM_DQ_OUT;
    logic [SRAM_DATA_LEN-1:0] SRAM_DQ_IN;
    logic                     SRAM_DQ_OE;
    logic                     SRAM_WE_N;
    logic                     addr_err;

    // pipeline + SRAM device side
    modport master (
        output MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, SRAM_DQ_IN,
        input  ready, rdata, SRAM_ADDR, SRAM_DQ_OUT, SRAM_DQ_OE, SRAM_WE_N, addr_err
    );

    // controller side
    modport slave (
        input  MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, SRAM_DQ_IN,
        output ready, rdata, SRAM_ADDR, SRAM_DQ_OUT, SRAM_DQ_OE, SRAM_WE_N, addr_err
    );
endinterface

// File: rtl/mem_stage_sram_ctrl_timer.sv
// Purpose: loadable down-counter timing how long each halfword access is held on the bus.
// Latency: expire_o rises WAIT_CYCLES-1 cycles after the load cycle (same cycle when WAIT_CYCLES=1).
// Backpressure: none; load_i always wins over counting.
module sram_wait_timer
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_D
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic expire_o
);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // reload on state entry, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Purpose: MEM-stage sequencer running each 32-bit load/store as two 16-bit SRAM accesses.
// Latency: ready low 1+2*WAIT_CYCLES cycles per access, then high for one DONE cycle.
// Backpressure: ready=0 freezes upstream; `MEM_RANGE_CHECK_EN rejects out-of-range addresses.
module mem_stage_sram_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_LEN      = DATA_LEN_D,
    parameter int SRAM_DATA_LEN = SRAM_DATA_LEN_D,
    parameter int SRAM_ADDR_LEN = SRAM_ADDR_LEN_D,
    parameter int BASE_ADDR     = BASE_ADDR_D,
    parameter int WAIT_CYCLES   = WAIT_CYCLES_D
) (
    input logic                  clk,
    input logic                  rst,
    mem_stage_sram_ctrl_if.slave bus
);
    // word index: halfword address without its LSB
    localparam int WL = SRAM_ADDR_LEN - 1;

    mem_state_e               state_q, state_d;
    logic                     req;
    logic                     expire;
    logic                     tmr_load;
    logic                     range_bad;
    logic [DATA_LEN-1:0]      off_full;
    logic                     is_wr_q;
    logic [WL-1:0]            word_q;
    logic [DATA_LEN-1:0]      wdata_q;
    logic [SRAM_DATA_LEN-1:0] lo_q;
    logic [DATA_LEN-1:0]      rdata_q;
    logic                     ready;
    logic                     oe;
    logic                     we_n;
    logic [SRAM_ADDR_LEN-1:0] sram_addr;
    logic [SRAM_DATA_LEN-1:0] dq_out;
    logic                     unused_off_bits;

    assign req      = bus.MEM_R_EN | bus.MEM_W_EN;
    assign off_full = bus.ALU_Res - DATA_LEN'(BASE_ADDR);
    // byte-lane bits and bits above the SRAM window only matter to the range check
    assign unused_off_bits = ^{off_full[1:0], off_full[DATA_LEN-1:SRAM_ADDR_LEN+1]};

`ifdef MEM_RANGE_CHECK_EN
    logic err_q;
    assign range_bad = (bus.ALU_Res < DATA_LEN'(BASE_ADDR)) ||
                       (off_full[DATA_LEN-1:SRAM_ADDR_LEN+1] != '0);

    // remember whether the current DONE is a rejected access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (state_q == ST_IDLE && req) begin
            err_q <= range_bad;
        end
    end
    assign bus.addr_err = (state_q == ST_DONE) && err_q;
`else
    assign range_bad    = 1'b0;
    assign bus.addr_err = 1'b0;
`endif

    // one timer shared by both halves, restarted whenever LO or HI is entered
    assign tmr_load = (state_d != state_q) && ((state_d == ST_LO) || (state_d == ST_HI));

    sram_wait_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (tmr_load),
        .expire_o (expire)
    );

    // state register; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state: requests are only looked at in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req)    state_d = range_bad ? ST_DONE : ST_LO;
            ST_LO:   if (expire) state_d = ST_HI;
            ST_HI:   if (expire) state_d = ST_DONE;
            ST_DONE:             state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
    end

    // request latch and load assembly; rdata only changes once the full word is in
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_wr_q <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == ST_IDLE && req) begin
                is_wr_q <= bus.MEM_W_EN;
                word_q  <= off_full[SRAM_ADDR_LEN:2];
                wdata_q <= bus.Val_Rm;
            end
            if (state_q == ST_LO && expire && !is_wr_q) begin
                lo_q <= bus.SRAM_DQ_IN;
            end
            if (state_q == ST_HI && expire && !is_wr_q) begin
                rdata_q <= {bus.SRAM_DQ_IN, lo_q};
            end
        end
    end

    // outputs: pins idle outside LO/HI; WE_N released on the last LO cycle to split the two writes
    always_comb begin
        ready     = 1'b0;
        sram_addr = '0;
        dq_out    = '0;
        oe        = 1'b0;
        we_n      = 1'b1;
        case (state_q)
            ST_IDLE: ready = !req;
            ST_LO: begin
                sram_addr = {word_q, 1'b0};
                if (is_wr_q) begin
                    dq_out = wdata_q[SRAM_DATA_LEN-1:0];
                    oe     = 1'b1;
                    we_n   = expire;
                end
            end
            ST_HI: begin
                sram_addr = {word_q, 1'b1};
                if (is_wr_q) begin
                    dq_out = wdata_q[DATA_LEN-1:SRAM_DATA_LEN];
                    oe     = 1'b1;
                    we_n   = 1'b0;
                end
            end
            ST_DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign bus.ready       = ready;
    assign bus.rdata       = rdata_q;
    assign bus.SRAM_ADDR   = sram_addr;
    assign bus.SRAM_DQ_OUT = dq_out;
    assign bus.SRAM_DQ_OE  = oe;
    assign bus.SRAM_WE_N   = we_n;
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Purpose: bench for mem_stage_sram_ctrl with an SRAM model and a transaction-timeline reference.
// Latency: reference expects ready low 1+2*WAIT_CYCLES cycles (1 for a rejected access).
// Backpressure: stimulus holds requests until ready; MEM_RANGE_CHECK_EN adds the reject case.
module tb_mem_stage_sram_ctrl;
    import mem_ctrl_pkg::*;

    localparam int W    = WAIT_CYCLES_D;
    localparam int BASE = BASE_ADDR_D;
`ifdef MEM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_stage_sram_ctrl_if bus ();

    mem_stage_sram_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // external SRAM: asynchronous read, write on the rising edge while WE_N is low
    logic [15:0] sram [0:(1<<18)-1];
    assign bus.SRAM_DQ_IN = sram[bus.SRAM_ADDR];
    always @(posedge clk) begin
        if (!bus.SRAM_WE_N && bus.SRAM_DQ_OE) sram[bus.SRAM_ADDR] <= bus.SRAM_DQ_OUT;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'(BASE);
        return RANGE_EN && ((a < 32'(BASE)) || (off >= 32'h0008_0000));
    endfunction

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'(BASE);
        return int'((off >> 2) & 32'h0001_FFFF);
    endfunction

    // ---------------- reference model: word memory + per-access cycle timeline ----------------
    logic [31:0] ref_mem [int];
    int          k = -1;          // cycle index inside the current access, -1 when none
    int          last;
    bit          t_wr, t_bad, hi;
    int          t_w;
    logic [31:0] t_data, t_load;
    logic [31:0] rdata_exp = 32'h0;
    logic [31:0] e_addr, e_dq;
    bit          e_oe, e_wen, e_rdy, e_err;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                k         = -1;
                rdata_exp = 32'h0;
            end else if (k < 0 && (bus.MEM_R_EN || bus.MEM_W_EN)) begin
                t_w    = word_of(bus.ALU_Res);
                t_wr   = bus.MEM_W_EN;
                t_data = bus.Val_Rm;
                t_bad  = is_bad(bus.ALU_Res);
                if (!t_bad) begin
                    if (t_wr) ref_mem[t_w] = t_data;
                    else      t_load = ref_mem[t_w];
                end
                k = 0;
            end
            last   = t_bad ? 1 : 2 * W + 1;
            e_addr = 32'h0;
            e_dq   = 32'h0;
            e_oe   = 1'b0;
            e_wen  = 1'b1;
            e_err  = 1'b0;
            e_rdy  = (k < 0) ? !(bus.MEM_R_EN || bus.MEM_W_EN) : (k == last);
            if (k >= 1 && k <= 2 * W && !t_bad) begin
                hi     = (k > W);
                e_addr = 32'(2 * t_w + (hi ? 1 : 0));
                if (t_wr) begin
                    e_oe  = 1'b1;
                    e_dq  = hi ? (t_data >> 16) : (t_data & 32'h0000_FFFF);
                    e_wen = hi ? 1'b0 : (k == W);
                end
            end
            if (k >= 0 && k == last) begin
                e_err = t_bad;
                if (!t_wr && !t_bad) rdata_exp = t_load;
            end
            check("ready",     32'(bus.ready),       32'(e_rdy));
            check("rdata",     bus.rdata,            rdata_exp);
            check("sram_addr", 32'(bus.SRAM_ADDR),   e_addr);
            check("dq_out",    32'(bus.SRAM_DQ_OUT), e_dq);
            check("dq_oe",     32'(bus.SRAM_DQ_OE),  32'(e_oe));
            check("we_n",      32'(bus.SRAM_WE_N),   32'(e_wen));
            check("addr_err",  32'(bus.addr_err),    32'(e_err));
            if (k >= 0) k = (k == last) ? -1 : k + 1;
        end
    end

    // ---------------- stimulus ----------------
    // called just after a rising edge with the DUT in IDLE; returns just after the edge leaving DONE
    task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input bit scr, output int lc, output bit err);
        bit got;
        bus.MEM_R_EN = r;
        bus.MEM_W_EN = w;
        bus.ALU_Res  = a;
        bus.Val_Rm   = d;
        lc  = 0;
        err = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                got = 1'b1;
                err = bus.addr_err;
                break;
            end
            lc++;
            @(posedge clk);
            #1;
            if (scr) begin
                bus.MEM_R_EN = 1'($urandom_range(0, 1));
                bus.MEM_W_EN = 1'($urandom_range(0, 1));
                bus.ALU_Res  = $urandom;
                bus.Val_Rm   = $urandom;
            end
        end
        check("access_done", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] pool [10];
    logic [31:0] saved;
    logic [15:0] old_hi;
    int          lc;
    bit          err;

    initial begin
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
        bus.ALU_Res  = 32'h0;
        bus.Val_Rm   = 32'h0;
        rst          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",   32'(bus.ready),       32'd1);
        check("rst_rdata",   bus.rdata,            32'd0);
        check("rst_addr",    32'(bus.SRAM_ADDR),   32'd0);
        check("rst_dq",      32'(bus.SRAM_DQ_OUT), 32'd0);
        check("rst_oe",      32'(bus.SRAM_DQ_OE),  32'd0);
        check("rst_we_n",    32'(bus.SRAM_WE_N),   32'd1);
        check("rst_addrerr", 32'(bus.addr_err),    32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // store 0xDEADBEEF @1032 -> halfwords 4/5
        access(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 1'b0, lc, err);
        check("store_low_cycles", 32'(lc), 32'd5);
        check("store_sram4", 32'(sram[4]), 32'h0000_BEEF);
        check("store_sram5", 32'(sram[5]), 32'h0000_DEAD);

        // load it back
        access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, lc, err);
        check("load_low_cycles", 32'(lc), 32'd5);
        check("load_rdata", bus.rdata, 32'hDEAD_BEEF);

        // read and write together is a store
        access(1'b1, 1'b1, 32'd1024, 32'h1234_5678, 1'b0, lc, err);
        check("rw_sram0", 32'(sram[0]), 32'h0000_5678);
        check("rw_sram1", 32'(sram[1]), 32'h0000_1234);

        // back-to-back load then store, no idle gap
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, lc, err);
        access(1'b0, 1'b1, 32'd1028, 32'hA5A5_5A5A, 1'b0, lc, err);
        check("b2b_low_cycles", 32'(lc), 32'd5);
        check("b2b_rdata", bus.rdata, 32'h1234_5678);
        check("b2b_sram2", 32'(sram[2]), 32'h0000_5A5A);
        check("b2b_sram3", 32'(sram[3]), 32'h0000_A5A5);

`ifdef MEM_RANGE_CHECK_EN
        // below the base: rejected after one cycle, rdata untouched
        access(1'b1, 1'b0, 32'd512, 32'h0, 1'b0, lc, err);
        check("range_low_cycles", 32'(lc), 32'd1);
        check("range_addr_err", 32'(err), 32'd1);
        check("range_rdata", bus.rdata, 32'h1234_5678);
`endif

        // pool mixes aliases: 1034~1032, 1040~wrap+16, 1020~top word
        pool[0] = 32'd1024;  pool[1] = 32'd1028;  pool[2] = 32'd1032;  pool[3] = 32'd1034;
        pool[4] = 32'd1060;  pool[5] = 32'd1040;  pool[6] = 32'(BASE + (1 << 19) - 4);
        pool[7] = 32'(BASE + (1 << 19) + 16);     pool[8] = 32'd1020;  pool[9] = 32'd1036;
        for (int i = 0; i < 10; i++) access(1'b0, 1'b1, pool[i], $urandom, 1'b0, lc, err);

        // reset during the first HI cycle of a store to word 9 (halfwords 18/19)
        saved  = ref_mem[9];
        old_hi = saved[31:16];
        bus.MEM_W_EN = 1'b1;
        bus.ALU_Res  = 32'd1060;
        bus.Val_Rm   = 32'hCAFE_F00D;
        repeat (1 + W) @(posedge clk);
        #2;
        bus.MEM_W_EN = 1'b0;
        rst          = 1'b0;
        #1;
        check("abort_we_n",  32'(bus.SRAM_WE_N),  32'd1);
        check("abort_oe",    32'(bus.SRAM_DQ_OE), 32'd0);
        check("abort_ready", 32'(bus.ready),      32'd1);
        check("abort_addr",  32'(bus.SRAM_ADDR),  32'd0);
        check("abort_rdata", bus.rdata,           32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        check("abort_sram18", 32'(sram[18]), 32'h0000_F00D);
        check("abort_sram19", 32'(sram[19]), 32'(old_hi));
        ref_mem[9] = {old_hi, 16'hF00D};
        @(posedge clk);
        #1;

        // randomized traffic with gaps, aliasing and input noise while busy
        for (int n = 0; n < 150; n++) begin
            int  idx, op, gap;
            bit  r, w;
            idx = int'($urandom_range(0, 9));
            op  = int'($urandom_range(0, 3));
            gap = int'($urandom_range(0, 2));
            r   = (op != 1);
            w   = (op == 1) || (op == 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            access(r, w, pool[idx], $urandom, 1'($urandom_range(0, 1)), lc, err);
            check("rand_low_cycles", 32'(lc), is_bad(pool[idx]) ? 32'd1 : 32'(1 + 2 * W));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
